// File: rtl/cpuif_arbiter.sv
// Two-requester round-robin arbiter in front of a single CPU-interface regblock port.
// One transaction in flight at a time. A WAIT-phase timeout returns an error response.
module cpuif_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    arst_n,

  input  logic [1:0]              s_req,
  input  logic [1:0]              s_req_is_wr,
  input  logic [2*ADDR_WIDTH-1:0] s_addr,
  input  logic [2*DATA_WIDTH-1:0] s_wr_data,
  input  logic [2*DATA_WIDTH-1:0] s_wr_biten,
  output logic [1:0]              s_req_stall,
  output logic [1:0]              s_rd_ack,
  output logic [1:0]              s_wr_ack,
  output logic [1:0]              s_err,
  output logic [DATA_WIDTH-1:0]   s_rd_data,

  output logic                    m_req,
  output logic                    m_req_is_wr,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wr_data,
  output logic [DATA_WIDTH-1:0]   m_wr_biten,
  input  logic                    m_req_stall_wr,
  input  logic                    m_req_stall_rd,
  input  logic                    m_rd_ack,
  input  logic                    m_wr_ack,
  input  logic                    m_rd_err,
  input  logic                    m_wr_err,
  input  logic [DATA_WIDTH-1:0]   m_rd_data
);

  localparam int NUM_REQ = 2;
  localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W   = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                state, state_nxt;
  logic                  last_grant, grant, cur_gnt;
  logic                  is_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, biten_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  idle, busy, accept, stall_sel;
  logic                  ack_match, timeout, done, done_err;
  logic [NUM_REQ-1:0]    take_vec, own_vec;

  // Tie goes to whoever was not served last; a lone request always wins.
  always_comb begin
    grant = s_req[1];
    if (s_req == 2'b11) grant = ~last_grant;
  end

  assign idle      = (state == IDLE);
  assign busy      = (state == ISSUE) || (state == WAIT);
  assign accept    = idle && (|s_req);
  assign stall_sel = is_wr_q ? m_req_stall_wr : m_req_stall_rd;
  assign ack_match = busy && (is_wr_q ? m_wr_ack : m_rd_ack);
  assign timeout   = TO_EN && (state == WAIT) && (cnt_q == TO_LAST);
  assign done      = ack_match || timeout;
  // A real ack outranks a simultaneous timeout.
  assign done_err  = ack_match ? (is_wr_q ? m_wr_err : m_rd_err) : 1'b1;

  assign take_vec = idle ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign own_vec  = cur_gnt ? 2'b10 : 2'b01;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
    assign s_req_stall[i] = s_req[i] & ~take_vec[i];
    assign s_rd_ack[i]    = own_vec[i] & done & ~is_wr_q;
    assign s_wr_ack[i]    = own_vec[i] & done &  is_wr_q;
    assign s_err[i]       = own_vec[i] & done &  done_err;
  end

  assign s_rd_data = (ack_match && !is_wr_q) ? m_rd_data : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|s_req) state_nxt = ISSUE;
      ISSUE: begin
        if (ack_match)       state_nxt = IDLE;
        else if (!stall_sel) state_nxt = WAIT;
      end
      WAIT:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_gnt    <= 1'b0;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      biten_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant;
        cur_gnt    <= grant;
        is_wr_q    <= s_req_is_wr[grant];
        addr_q     <= grant ? s_addr[ADDR_WIDTH +: ADDR_WIDTH]     : s_addr[0 +: ADDR_WIDTH];
        wdata_q    <= grant ? s_wr_data[DATA_WIDTH +: DATA_WIDTH]  : s_wr_data[0 +: DATA_WIDTH];
        biten_q    <= grant ? s_wr_biten[DATA_WIDTH +: DATA_WIDTH] : s_wr_biten[0 +: DATA_WIDTH];
      end
      if (state == ISSUE && state_nxt == WAIT) cnt_q <= '0;
      else if (state == WAIT)                  cnt_q <= cnt_q + 1'b1;
    end
  end

  assign m_req       = (state == ISSUE);
  assign m_req_is_wr = is_wr_q;
  assign m_addr      = addr_q;
  assign m_wr_data   = wdata_q;
  assign m_wr_biten  = biten_q;

endmodule

// File: tb/tb_cpuif_arbiter.sv
// Directed bench for cpuif_arbiter with TIMEOUT_CYCLES=4.
// Inputs change 1ns after posedge; outputs are checked 1ns later.
module tb_cpuif_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk, arst_n;
  logic [1:0]    s_req, s_req_is_wr, s_req_stall, s_rd_ack, s_wr_ack, s_err;
  logic [2*AW-1:0] s_addr;
  logic [2*DW-1:0] s_wr_data, s_wr_biten;
  logic [DW-1:0] s_rd_data;
  logic          m_req, m_req_is_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wr_data, m_wr_biten, m_rd_data;
  logic          m_req_stall_wr, m_req_stall_rd, m_rd_ack, m_wr_ack, m_rd_err, m_wr_err;

  int checks = 0;
  int errors = 0;

  cpuif_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .arst_n(arst_n),
    .s_req(s_req), .s_req_is_wr(s_req_is_wr), .s_addr(s_addr),
    .s_wr_data(s_wr_data), .s_wr_biten(s_wr_biten),
    .s_req_stall(s_req_stall), .s_rd_ack(s_rd_ack), .s_wr_ack(s_wr_ack),
    .s_err(s_err), .s_rd_data(s_rd_data),
    .m_req(m_req), .m_req_is_wr(m_req_is_wr), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_wr_biten(m_wr_biten),
    .m_req_stall_wr(m_req_stall_wr), .m_req_stall_rd(m_req_stall_rd),
    .m_rd_ack(m_rd_ack), .m_wr_ack(m_wr_ack), .m_rd_err(m_rd_err),
    .m_wr_err(m_wr_err), .m_rd_data(m_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_n = 1'b0;
    s_req = '0; s_req_is_wr = '0; s_addr = '0; s_wr_data = '0; s_wr_biten = '0;
    m_req_stall_wr = 0; m_req_stall_rd = 0; m_rd_ack = 0; m_wr_ack = 0;
    m_rd_err = 0; m_wr_err = 0; m_rd_data = '0;
    #2;
    chk("rst_m_req", 64'(m_req), 64'd0);
    chk("rst_acks", 64'({s_rd_ack, s_wr_ack, s_err}), 64'd0);
    chk("rst_stall", 64'(s_req_stall), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    @(negedge clk);
    arst_n = 1'b1;

    // Round robin: both request continuously; downstream acks immediately.
    s_req = 2'b11; s_addr = {8'h31, 8'h20}; m_rd_ack = 1; m_rd_data = 32'h1234_5678;
    #1;
    chk("rr_stall_a", 64'(s_req_stall), 64'h2);
    chk("rr_idle_ack_ignored", 64'(s_rd_ack), 64'd0);
    cyc; #1;
    chk("rr_m_req_a", 64'(m_req), 64'd1);
    chk("rr_addr_a", 64'(m_addr), 64'h20);
    chk("rr_ack_a", 64'(s_rd_ack), 64'h1);
    chk("rr_data_a", 64'(s_rd_data), 64'h1234_5678);
    chk("rr_stall_issue", 64'(s_req_stall), 64'h3);
    cyc; #1;
    chk("rr_stall_b", 64'(s_req_stall), 64'h1);
    chk("rr_idle_noack", 64'(s_rd_ack), 64'd0);
    chk("rr_idle_m_req", 64'(m_req), 64'd0);
    cyc; #1;
    chk("rr_addr_b", 64'(m_addr), 64'h31);
    chk("rr_ack_b", 64'(s_rd_ack), 64'h2);
    cyc; #1;
    chk("rr_stall_c", 64'(s_req_stall), 64'h2);
    cyc; #1;
    chk("rr_addr_c", 64'(m_addr), 64'h20);
    chk("rr_ack_c", 64'(s_rd_ack), 64'h1);
    cyc; #1;
    chk("rr_stall_d", 64'(s_req_stall), 64'h1);
    cyc; s_req = 2'b00; #1;
    chk("rr_addr_d", 64'(m_addr), 64'h31);
    chk("rr_ack_d", 64'(s_rd_ack), 64'h2);
    cyc; m_rd_ack = 0; #1;
    chk("rr_done_m_req", 64'(m_req), 64'd0);

    // Single read from requester 0, ack two cycles after m_req.
    cyc; s_req = 2'b01; s_addr[7:0] = 8'h10; #1;
    chk("rd_accept", 64'(s_req_stall), 64'd0);
    cyc; s_req = 2'b00; #1;
    chk("rd_m_req", 64'(m_req), 64'd1);
    chk("rd_m_addr", 64'(m_addr), 64'h10);
    chk("rd_m_is_wr", 64'(m_req_is_wr), 64'd0);
    cyc; #1;
    chk("rd_wait_m_req", 64'(m_req), 64'd0);
    chk("rd_wait_noack", 64'(s_rd_ack), 64'd0);
    cyc; m_rd_ack = 1; m_rd_data = 32'hDEAD_BEEF; #1;
    chk("rd_ack", 64'(s_rd_ack), 64'h1);
    chk("rd_data", 64'(s_rd_data), 64'hDEAD_BEEF);
    chk("rd_err", 64'(s_err), 64'd0);
    cyc; m_rd_ack = 0; #1;
    chk("rd_ack_clear", 64'(s_rd_ack), 64'd0);
    chk("rd_data_zero", 64'(s_rd_data), 64'd0);

    // Write from requester 1 with three stalled cycles.
    cyc;
    s_req = 2'b10; s_req_is_wr = 2'b10; s_addr = {8'h44, 8'h10};
    s_wr_data = {32'hA5A5_0001, 32'h0}; s_wr_biten = {32'hFFFF_0000, 32'h0};
    m_req_stall_wr = 1; #1;
    chk("wr_accept", 64'(s_req_stall), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc; s_req = 2'b00; #1;
      chk("wr_stall_m_req", 64'(m_req), 64'd1);
      chk("wr_stall_is_wr", 64'(m_req_is_wr), 64'd1);
      chk("wr_stall_addr", 64'(m_addr), 64'h44);
      chk("wr_stall_data", 64'(m_wr_data), 64'hA5A5_0001);
      chk("wr_stall_biten", 64'(m_wr_biten), 64'hFFFF_0000);
      chk("wr_stall_noack", 64'(s_wr_ack), 64'd0);
    end
    cyc; m_req_stall_wr = 0; m_wr_ack = 1; #1;
    chk("wr_last_m_req", 64'(m_req), 64'd1);
    chk("wr_last_addr", 64'(m_addr), 64'h44);
    chk("wr_ack", 64'(s_wr_ack), 64'h2);
    chk("wr_err", 64'(s_err), 64'd0);
    chk("wr_no_rd_ack", 64'(s_rd_ack), 64'd0);
    cyc; m_wr_ack = 0; #1;
    chk("wr_done_m_req", 64'(m_req), 64'd0);
    chk("wr_ack_single", 64'(s_wr_ack), 64'd0);

    // Timeout on a read from requester 0 after 4 WAIT cycles.
    cyc; s_req = 2'b01; s_req_is_wr = 2'b00; s_addr[7:0] = 8'h55; #1;
    chk("to_accept", 64'(s_req_stall), 64'd0);
    cyc; s_req = 2'b00; #1;
    chk("to_m_addr", 64'(m_addr), 64'h55);
    cyc; m_rd_data = 32'hCAFE_F00D; #1;
    chk("to_w1", 64'(s_rd_ack), 64'd0);
    cyc; m_wr_ack = 1; #1;
    chk("to_w2_wrong_type_wr", 64'(s_wr_ack), 64'd0);
    chk("to_w2_wrong_type_rd", 64'(s_rd_ack), 64'd0);
    cyc; m_wr_ack = 0; #1;
    chk("to_w3", 64'({s_rd_ack, s_err}), 64'd0);
    cyc; #1;
    chk("to_ack", 64'(s_rd_ack), 64'h1);
    chk("to_err", 64'(s_err), 64'h1);
    chk("to_data_zero", 64'(s_rd_data), 64'd0);
    cyc; m_rd_ack = 1; #1;
    chk("to_stray_ack", 64'(s_rd_ack), 64'd0);
    chk("to_stray_err", 64'(s_err), 64'd0);
    chk("to_idle_m_req", 64'(m_req), 64'd0);
    cyc; m_rd_ack = 0;

    // Reset pulse during WAIT, then tie must go to requester 0 again.
    cyc; s_req = 2'b01; s_addr[7:0] = 8'h66; #1;
    chk("rst_wait_accept", 64'(s_req_stall), 64'd0);
    cyc; s_req = 2'b00; #1;
    chk("rst_wait_m_req", 64'(m_req), 64'd1);
    cyc; #1;
    arst_n = 1'b0; #1;
    chk("rst_pulse_m_req", 64'(m_req), 64'd0);
    chk("rst_pulse_acks", 64'({s_rd_ack, s_wr_ack, s_err}), 64'd0);
    arst_n = 1'b1;
    s_req = 2'b11; s_addr = {8'h77, 8'h66}; #1;
    chk("rst_tie_stall", 64'(s_req_stall), 64'h2);
    cyc; s_req = 2'b10; #1;
    chk("rst_tie_m_req", 64'(m_req), 64'd1);
    chk("rst_tie_addr", 64'(m_addr), 64'h66);
    chk("rst_tie_noack", 64'(s_rd_ack), 64'd0);
    cyc; m_rd_ack = 1; m_rd_data = 32'h0BAD_F00D; #1;
    chk("rst_tie_ack", 64'(s_rd_ack), 64'h1);
    chk("rst_tie_data", 64'(s_rd_data), 64'h0BAD_F00D);
    cyc; m_rd_ack = 0; #1;
    chk("rst_next_stall", 64'(s_req_stall), 64'd0);
    cyc; s_req = 2'b00; m_rd_ack = 1; m_rd_err = 1; #1;
    chk("rst_next_addr", 64'(m_addr), 64'h77);
    chk("rst_next_ack", 64'(s_rd_ack), 64'h2);
    chk("rst_next_err", 64'(s_err), 64'h2);
    cyc; m_rd_ack = 0; m_rd_err = 0; #1;
    chk("end_idle", 64'({m_req, s_rd_ack, s_err}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
